// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-grant beat budget from latched weight.
// Optional macro WRR_LOCK_EN adds lock_i, which holds the grant past its weight limit.
module wrr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 4,
    localparam int IDW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
    input  logic                          ack_i,
`ifdef WRR_LOCK_EN
    input  logic                          lock_i,
`endif
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic                          gnt_valid_o,
    output logic [IDW-1:0]                gnt_id_o
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [IDW:0]   NP_W = (IDW+1)'(NUM_PORTS);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_PORTS-1);

    state_t                state_q, state_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]   cnt_q, cnt_d;
    logic [WEIGHT_W-1:0]   wt_q, wt_d;

    logic [IDW-1:0]        rel_ptr, base, off, win;
    logic [IDW:0]          sum;
    logic [WEIGHT_W-1:0]   win_wt;
    logic [WEIGHT_W-1:0]   wt_arr [NUM_PORTS];
    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]  req_rot;
    logic                  found, at_limit, do_release, lock;

`ifdef WRR_LOCK_EN
    assign lock = lock_i;
`else
    assign lock = 1'b0;
`endif

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wt
        assign wt_arr[g] = weight_i[g*WEIGHT_W +: WEIGHT_W];
    end

    // Rotate requests so the search base sits at bit 0, then take the lowest set bit.
    always_comb begin
        rel_ptr = (id_q == LAST) ? '0 : id_q + 1'b1;
        base    = (state_q == GRANT) ? rel_ptr : ptr_q;
        req_dbl = {req_i, req_i} >> base;
        req_rot = req_dbl[NUM_PORTS-1:0];
        found   = 1'b0;
        off     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NP_W) begin
            sum = sum - NP_W;
        end
        win    = sum[IDW-1:0];
        win_wt = (wt_arr[win] == '0) ? WEIGHT_W'(1) : wt_arr[win];
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        wt_d       = wt_q;
        at_limit   = (cnt_q == wt_q - 1'b1);
        do_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    id_d    = win;
                    cnt_d   = '0;
                    wt_d    = win_wt;
                end
            end
            GRANT: begin
                do_release = !req_i[id_q] || (ack_i && at_limit && !lock);
                if (do_release) begin
                    ptr_d = rel_ptr;
                    if (found) begin
                        id_d  = win;
                        cnt_d = '0;
                        wt_d  = win_wt;
                    end else begin
                        state_d = IDLE;
                        id_d    = '0;
                        cnt_d   = '0;
                    end
                end else if (ack_i && !at_limit) begin
                    // Reaching the limit without release only happens under lock: saturate.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wt_q    <= WEIGHT_W'(1);
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wt_q    <= wt_d;
        end
    end

    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_id_o    = id_q;
    assign gnt_o       = gnt_valid_o ? (NUM_PORTS'(1) << id_q) : '0;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Testbench for wrr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            ack;
    logic            lock;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [1:0]      gnt_id;

    int checks = 0;
    int fails  = 0;

    int m_gnt, m_ptr, m_beats, m_wt;

    logic [3:0] seq28 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] seq29 [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                              4'b0001, 4'b0001, 4'b0001, 4'b0010};

    wrr_arbiter #(.NUM_PORTS(N), .WEIGHT_W(WW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req),
        .weight_i   (weight),
        .ack_i      (ack),
`ifdef WRR_LOCK_EN
        .lock_i     (lock),
`endif
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_from(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int eff_w(input int p);
        int w;
        w = int'(weight[p*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic a);
        int w;
        bit rel;
        if (m_gnt < 0) begin
            w = find_from(m_ptr, r);
            if (w >= 0) begin
                m_gnt   = w;
                m_beats = 0;
                m_wt    = eff_w(w);
            end
        end else begin
            rel = !r[m_gnt] || (a && (m_beats + 1 == m_wt));
            if (rel) begin
                m_ptr   = (m_gnt + 1) % N;
                w       = find_from(m_ptr, r);
                m_gnt   = w;
                m_beats = 0;
                if (w >= 0) m_wt = eff_w(w);
            end else if (a) begin
                m_beats++;
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [31:0] eg, eid, ev;
        eg  = (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0;
        eid = (m_gnt >= 0) ? 32'(m_gnt) : 32'd0;
        ev  = (m_gnt >= 0) ? 32'd1 : 32'd0;
        chk({tag, ".gnt"}, 32'(gnt), eg);
        chk({tag, ".valid"}, 32'(gnt_valid), ev);
        chk({tag, ".id"}, 32'(gnt_id), eid);
    endtask

    task automatic step(input string tag);
        logic [N-1:0] r;
        logic a;
        @(posedge clk);
        r = req;
        a = ack;
        if (!reset_n) begin
            m_gnt = -1; m_ptr = 0; m_beats = 0;
        end else begin
            model_edge(r, a);
        end
        #1;
        compare(tag);
    endtask

    // Asserts reset between edges so the asynchronous clear is observable before any clock.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        m_gnt = -1; m_ptr = 0; m_beats = 0; m_wt = 1;
        #1;
        compare("reset_async");
        step("in_reset");
        step("in_reset");
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        req     = '0;
        ack     = 1'b0;
        weight  = '0;
        lock    = 1'b0;
        m_gnt = -1; m_ptr = 0; m_beats = 0; m_wt = 1;

        // Plain round robin, every weight 1
        do_reset();
        weight = {4{4'd1}};
        req    = 4'b1111;
        ack    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("rr");
            chk("rr_seq", 32'(gnt), 32'(seq28[i]));
        end

        // Weighted: p0=3, p1=1
        do_reset();
        weight = 16'h0013;
        req    = 4'b0011;
        ack    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("wrr");
            chk("wrr_seq", 32'(gnt), 32'(seq29[i]));
        end

        // Ack stall on p2 (weight 4)
        do_reset();
        weight = 16'h0400;
        req    = 4'b0100;
        ack    = 1'b0;
        step("stall");
        chk("stall_grant", 32'(gnt), 32'h4);
        for (int i = 0; i < 5; i++) begin
            step("stall");
            chk("stall_hold", 32'(gnt), 32'h4);
        end
        req = 4'b0101;
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("beats");
            chk("beats_hold", 32'(gnt), 32'h4);
        end
        step("beats");
        chk("beats_release", 32'(gnt), 32'h1);
        step("beats");
        chk("beats_next", 32'(gnt), 32'h4);

        // Request drop on p1 (weight 5) with p3 waiting
        do_reset();
        weight = 16'h1050;
        req    = 4'b0010;
        ack    = 1'b1;
        step("drop");
        chk("drop_grant", 32'(gnt), 32'h2);
        req = 4'b1010;
        step("drop");
        chk("drop_beat1", 32'(gnt), 32'h2);
        step("drop");
        chk("drop_beat2", 32'(gnt), 32'h2);
        req = 4'b1000;
        step("drop");
        chk("drop_to_p3", 32'(gnt), 32'h8);
        req = 4'b1011;
        step("drop");
        chk("ptr_wrap_p0", 32'(gnt), 32'h1);

        // Reset mid-burst on p3
        do_reset();
        weight = 16'h8000;
        req    = 4'b1000;
        ack    = 1'b1;
        step("burst");
        chk("burst_grant", 32'(gnt), 32'h8);
        step("burst");
        step("burst");
        do_reset();
        req = 4'b1010;
        step("post_reset");
        chk("post_reset_p1", 32'(gnt), 32'h2);
        chk("post_reset_id", 32'(gnt_id), 32'h1);

        // Randomized traffic, including zero weights and a reset partway through
        do_reset();
        req = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            ack = ($urandom_range(0, 3) != 0);
            if (c == 300) do_reset();
            step("rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters (legal 1..32, non-power-of-2 allowed).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-port weight field.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have req_i  input  NUM_PORTS  per-port request, bit i = port i.
REQ-006 SHALL have weight_i  input  NUM_PORTS*WEIGHT_W  packed weights, port i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-007 SHALL have ack_i  input  1  downstream accepts one beat of the granted port this cycle.
REQ-008 SHALL have gnt_o  output  NUM_PORTS  registered grant, one-hot or all-zero.
REQ-009 SHALL have gnt_valid_o  output  1  high when gnt_o is non-zero.
REQ-010 SHALL have gnt_id_o  output  max(1,$clog2(NUM_PORTS))  binary index of granted port; 0 when no grant.
REQ-011 SHALL have lock_i  input  1  hold current grant; present only under WRR_LOCK_EN.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one port owns grant).
REQ-013 SHALL hold a round-robin pointer ptr; winner = first set bit of req_i searching ptr, ptr+1, ..., wrapping modulo NUM_PORTS.
REQ-014 SHALL, in IDLE with any req_i bit set at edge t, assert gnt_o/gnt_id_o/gnt_valid_o for the winner from edge t (one-cycle registered latency); FSM -> GRANT.
REQ-015 SHALL latch the winner's weight at grant time; weight 0 is treated as 1; later weight_i changes do not affect the current grant.
REQ-016 SHALL keep a beat counter, cleared on every new grant, incremented on each cycle with gnt_valid_o & ack_i.
REQ-017 SHALL release the grant on the edge where ack_i is high and the counter reaches latched weight-1 (i.e. after exactly weight acked beats).
REQ-018 SHALL release the grant on the edge where req_i of the granted port is low, regardless of ack_i (a final beat acked that cycle still counts as accepted).
REQ-019 SHALL, on release, set ptr = (granted index + 1) mod NUM_PORTS.
REQ-020 SHALL, on release with other requests pending, grant the next winner (using the updated ptr) on the same edge with no idle cycle; the released port is eligible only if it is the sole requester, and then receives a fresh grant with counter 0.
REQ-021 SHALL return to IDLE with gnt_o=0 on release when no request is pending.
REQ-022 SHALL never change gnt_o except on a release; ack_i low holds the grant indefinitely.
REQ-023 SHALL keep gnt_valid_o == |gnt_o and gnt_id_o consistent with gnt_o in every cycle.

Reset
REQ-024 SHALL, while reset_n is low, force gnt_o=0, gnt_valid_o=0, gnt_id_o=0, ptr=0, counter=0, FSM=IDLE asynchronously.
REQ-025 SHALL abandon any in-progress grant on reset assertion mid-burst; after deassertion arbitration restarts from port 0.

Configuration
REQ-026 SHALL, with macro WRR_LOCK_EN defined, provide lock_i: while lock_i=1 in GRANT, the weight-limit release (REQ-017) is suppressed and the counter saturates; request-drop release (REQ-018) still applies.
REQ-027 SHALL, without WRR_LOCK_EN, omit lock_i and behave exactly as REQ-012..REQ-023.

Verification
REQ-028 SHALL cover: NUM_PORTS=4, all weights=1, req_i=4'b1111, ack_i=1 constant -> gnt_o 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-029 SHALL cover: weights {p0=3,p1=1}, req_i=4'b0011, ack_i=1 -> p0 granted 3 cycles, p1 1 cycle, repeating.
REQ-030 SHALL cover: p2 granted, weight 4, ack_i low 5 cycles then high -> gnt_o holds 0100 throughout and releases after 4 acked beats.
REQ-031 SHALL cover: p1 granted weight 5, req_i[1] drops after 2 beats with req_i[3]=1 -> gnt_o=1000 next cycle, ptr=2 then 0 after p3.
REQ-032 SHALL cover: reset_n pulsed low mid-burst on p3 -> outputs 0 immediately; after release with req_i=4'b1010 first grant is p1.
REQ-033 SHALL cover (WRR_LOCK_EN): p0 weight 2, lock_i=1, ack_i=1 for 6 cycles -> gnt_o=0001 all 6 cycles; lock_i=0 -> release next acked edge.
